// File: rtl/snake_pkg.sv
// Shared encodings for the snake head scheduler: directions, grid defaults
// and the step sequencer state encoding.
package snake_pkg;

  localparam int CELL_PX    = 16;
  localparam int GRID_W_DEF = 640 / CELL_PX;
  localparam int GRID_H_DEF = 480 / CELL_PX;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_MOVE    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_e;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame counter driven by the vsync falling edge; raises a step request every
// FRAMES_PER_STEP unpaused frames and holds it until the sequencer takes it.
module frame_tick_gen
  import snake_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iVGA_V_SYNC,
  input  logic       iPause,
  input  logic       i_take,
  output logic [7:0] o_frame_cnt,
  output logic       o_step_pend
);

  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  logic       r_vs_d;
  logic [7:0] r_frame_cnt;
  logic       r_step_req;
  logic       w_tick;
  logic       w_count;
  logic       w_set;

  assign w_tick  = r_vs_d & ~iVGA_V_SYNC;
  assign w_count = w_tick & ~iPause;
  assign w_set   = w_count & (r_frame_cnt == CNT_LAST);

  // The terminal tick itself is visible to an idle sequencer so the step
  // launches in the very next cycle instead of waiting on the register.
  assign o_step_pend = r_step_req | w_set;
  assign o_frame_cnt = r_frame_cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vs_d      <= 1'b1;
      r_frame_cnt <= '0;
      r_step_req  <= 1'b0;
    end else begin
      r_vs_d     <= iVGA_V_SYNC;
      r_step_req <= (r_step_req | w_set) & ~i_take;
      if (w_count) begin
        r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/snake_head_scheduler.sv
// Steps the snake head one grid cell per FRAMES_PER_STEP frames and publishes
// coordinates and direction together in a single cycle.
module snake_head_scheduler
  import snake_pkg::*;
#(
  parameter int GRID_W          = GRID_W_DEF,
  parameter int GRID_H          = GRID_H_DEF,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iVGA_V_SYNC,
  input  logic       iPause,
  input  logic       iDir_Valid,
  input  logic [1:0] iDir,
  output logic       oDir_Ready,
  output logic [5:0] oHead_X,
  output logic [4:0] oHead_Y,
  output logic [1:0] oDir,
  output logic       oStep,
  output logic [7:0] oFrame_Cnt
);

  localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
  localparam logic [5:0] X_RST = 6'(GRID_W / 2);
  localparam logic [4:0] Y_RST = 5'(GRID_H / 2);

  state_e     r_state;
  state_e     w_state_nxt;
  logic       w_take;
  logic       w_step_pend;
  logic [1:0] r_cur_dir;
  logic [1:0] r_pend_dir;
  logic [5:0] r_nx;
  logic [4:0] r_ny;

  frame_tick_gen #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_tick (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iVGA_V_SYNC (iVGA_V_SYNC),
    .iPause      (iPause),
    .i_take      (w_take),
    .o_frame_cnt (oFrame_Cnt),
    .o_step_pend (w_step_pend)
  );

  assign oDir_Ready = (r_state == ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_step_pend) begin
          w_take      = 1'b1;
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH:   w_state_nxt = ST_MOVE;
      ST_MOVE:    w_state_nxt = ST_PUBLISH;
      ST_PUBLISH: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cur_dir  <= DIR_RIGHT;
      r_pend_dir <= DIR_RIGHT;
      r_nx       <= X_RST;
      r_ny       <= Y_RST;
      oHead_X    <= X_RST;
      oHead_Y    <= Y_RST;
      oDir       <= DIR_RIGHT;
      oStep      <= 1'b0;
    end else begin
      oStep <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (iDir_Valid) r_pend_dir <= iDir;
        end
        ST_LATCH: begin
          // A reversal would run the head into its own neck; drop it.
          if (!is_reverse(r_pend_dir, r_cur_dir)) begin
            r_cur_dir <= r_pend_dir;
          end else begin
            r_pend_dir <= r_cur_dir;
          end
        end
        ST_MOVE: begin
          r_nx <= oHead_X;
          r_ny <= oHead_Y;
          case (r_cur_dir)
            DIR_RIGHT: r_nx <= (oHead_X == X_MAX) ? 6'd0 : oHead_X + 6'd1;
            DIR_LEFT:  r_nx <= (oHead_X == 6'd0)  ? X_MAX : oHead_X - 6'd1;
            DIR_DOWN:  r_ny <= (oHead_Y == Y_MAX) ? 5'd0 : oHead_Y + 5'd1;
            DIR_UP:    r_ny <= (oHead_Y == 5'd0)  ? Y_MAX : oHead_Y - 5'd1;
            default:   r_nx <= oHead_X;
          endcase
        end
        ST_PUBLISH: begin
          oHead_X <= r_nx;
          oHead_Y <= r_ny;
          oDir    <= r_cur_dir;
          oStep   <= 1'b1;
        end
        default: oStep <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_scheduler.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the head scheduler (frames, pending steps, three-cycle busy window).
module tb_snake_head_scheduler;

  localparam int W = 40;
  localparam int H = 30;
  localparam int F = 8;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iVGA_V_SYNC = 1'b1;
  logic       iPause = 1'b0;
  logic       iDir_Valid = 1'b0;
  logic [1:0] iDir = 2'd0;
  logic       oDir_Ready;
  logic [5:0] oHead_X;
  logic [4:0] oHead_Y;
  logic [1:0] oDir;
  logic       oStep;
  logic [7:0] oFrame_Cnt;

  int n_checks = 0;
  int n_fail = 0;
  int step_seen = 0;

  logic       m_vs;
  logic [7:0] m_cnt;
  logic       m_req;
  int         m_busy;
  logic [1:0] m_pend, m_cur, m_dir;
  logic [5:0] m_x, m_nx;
  logic [4:0] m_y, m_ny;
  logic       m_step;

  snake_head_scheduler #(.GRID_W(W), .GRID_H(H), .FRAMES_PER_STEP(F)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iVGA_V_SYNC(iVGA_V_SYNC), .iPause(iPause),
    .iDir_Valid(iDir_Valid), .iDir(iDir), .oDir_Ready(oDir_Ready),
    .oHead_X(oHead_X), .oHead_Y(oHead_Y), .oDir(oDir), .oStep(oStep),
    .oFrame_Cnt(oFrame_Cnt)
  );

  always #5 iCLK = ~iCLK;

  task automatic model_reset();
    m_vs = 1'b1; m_cnt = 8'd0; m_req = 1'b0; m_busy = 0;
    m_pend = 2'd0; m_cur = 2'd0; m_dir = 2'd0;
    m_x = 6'd20; m_y = 5'd15; m_nx = 6'd20; m_ny = 5'd15; m_step = 1'b0;
  endtask

  // One clock edge of the reference: a step is planned in full when it is
  // launched and becomes visible three busy cycles later.
  task automatic model_edge();
    logic tick, term;
    if (!iRST_N) begin
      model_reset();
      return;
    end
    tick = m_vs && !iVGA_V_SYNC;
    m_vs = iVGA_V_SYNC;
    term = tick && !iPause && (int'(m_cnt) == F - 1);
    if (tick && !iPause) m_cnt = term ? 8'd0 : m_cnt + 8'd1;
    m_step = 1'b0;
    if (m_busy == 0) begin
      if (iDir_Valid) m_pend = iDir;
      if (m_req || term) begin
        if (((int'(m_pend) + 2) % 4) != int'(m_cur)) m_cur = m_pend;
        m_pend = m_cur;
        m_nx = m_x; m_ny = m_y;
        case (m_cur)
          2'd0: m_nx = 6'((int'(m_x) + 1) % W);
          2'd2: m_nx = 6'((int'(m_x) + W - 1) % W);
          2'd1: m_ny = 5'((int'(m_y) + 1) % H);
          default: m_ny = 5'((int'(m_y) + H - 1) % H);
        endcase
        m_busy = 3;
        m_req = 1'b0;
      end
    end else begin
      if (term) m_req = 1'b1;
      m_busy = m_busy - 1;
      if (m_busy == 0) begin
        m_x = m_nx; m_y = m_ny; m_dir = m_cur; m_step = 1'b1;
      end
    end
  endtask

  task automatic clk1();
    @(posedge iCLK);
    model_edge();
    @(negedge iCLK);
    if (oStep) step_seen++;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      iVGA_V_SYNC = 1'b0;
      clk1();
      iVGA_V_SYNC = 1'b1;
      repeat (5) clk1();
    end
  endtask

  task automatic apply_reset();
    iRST_N = 1'b0; iVGA_V_SYNC = 1'b1; iPause = 1'b0; iDir_Valid = 1'b0; iDir = 2'd0;
    clk1(); clk1();
    iRST_N = 1'b1;
    clk1();
  endtask

  task automatic test_reset();
    clk1(); clk1();
    iRST_N = 1'b1;
    n_checks++; if (oHead_X !== 6'd20) begin n_fail++; $display("FAIL reset_x got=%0d exp=20", oHead_X); end
    n_checks++; if (oHead_Y !== 5'd15) begin n_fail++; $display("FAIL reset_y got=%0d exp=15", oHead_Y); end
    n_checks++; if (oDir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got=%0d exp=0", oDir); end
    n_checks++; if (oStep !== 1'b0) begin n_fail++; $display("FAIL reset_step got=%0b exp=0", oStep); end
    n_checks++; if (oDir_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", oDir_Ready); end
    n_checks++; if (oFrame_Cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", oFrame_Cnt); end
    clk1();
  endtask

  task automatic test_basic_step();
    int s;
    apply_reset();
    frames(7);
    n_checks++; if (oFrame_Cnt !== 8'd7) begin n_fail++; $display("FAIL basic_cnt7 got=%0d exp=7", oFrame_Cnt); end
    s = step_seen;
    iVGA_V_SYNC = 1'b0;
    clk1();
    iVGA_V_SYNC = 1'b1;
    n_checks++; if (oDir_Ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_latch got=%0b exp=0", oDir_Ready); end
    clk1();
    n_checks++; if (oDir_Ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_move got=%0b exp=0", oDir_Ready); end
    clk1();
    n_checks++; if (oStep !== 1'b0 || oDir_Ready !== 1'b0) begin n_fail++; $display("FAIL basic_publish got step=%0b ready=%0b exp step=0 ready=0", oStep, oDir_Ready); end
    clk1();
    n_checks++; if (oStep !== 1'b1) begin n_fail++; $display("FAIL basic_step_t4 got=%0b exp=1", oStep); end
    n_checks++; if (oHead_X !== 6'd21 || oHead_Y !== 5'd15) begin n_fail++; $display("FAIL basic_head got=(%0d,%0d) exp=(21,15)", oHead_X, oHead_Y); end
    n_checks++; if (oFrame_Cnt !== 8'd0 || oDir_Ready !== 1'b1) begin n_fail++; $display("FAIL basic_cnt_ready got cnt=%0d ready=%0b exp cnt=0 ready=1", oFrame_Cnt, oDir_Ready); end
    clk1();
    n_checks++; if (oStep !== 1'b0 || step_seen != s + 1) begin n_fail++; $display("FAIL basic_single_pulse got step=%0b steps=%0d exp step=0 steps=%0d", oStep, step_seen - s, 1); end
  endtask

  task automatic test_wrap();
    apply_reset();
    frames(F * 19);
    n_checks++; if (oHead_X !== 6'd39) begin n_fail++; $display("FAIL wrap_x39 got=%0d exp=39", oHead_X); end
    frames(F);
    n_checks++; if (oHead_X !== 6'd0 || oHead_Y !== 5'd15) begin n_fail++; $display("FAIL wrap_right got=(%0d,%0d) exp=(0,15)", oHead_X, oHead_Y); end
    iDir_Valid = 1'b1; iDir = 2'd3;
    clk1();
    iDir_Valid = 1'b0;
    frames(F * 15);
    n_checks++; if (oHead_Y !== 5'd0 || oDir !== 2'd3) begin n_fail++; $display("FAIL wrap_y0 got y=%0d dir=%0d exp y=0 dir=3", oHead_Y, oDir); end
    frames(F);
    n_checks++; if (oHead_Y !== 5'd29 || oHead_X !== 6'd0) begin n_fail++; $display("FAIL wrap_up got=(%0d,%0d) exp=(0,29)", oHead_X, oHead_Y); end
  endtask

  task automatic test_reverse();
    apply_reset();
    iDir_Valid = 1'b1; iDir = 2'd2;
    n_checks++; if (oDir_Ready !== 1'b1) begin n_fail++; $display("FAIL rev_ready got=%0b exp=1", oDir_Ready); end
    clk1();
    iDir_Valid = 1'b0;
    frames(F);
    n_checks++; if (oDir !== 2'd0 || oHead_X !== 6'd21) begin n_fail++; $display("FAIL rev_reject got dir=%0d x=%0d exp dir=0 x=21", oDir, oHead_X); end
    iDir_Valid = 1'b1; iDir = 2'd1;
    clk1();
    iDir = 2'd3;
    clk1();
    iDir_Valid = 1'b0;
    frames(F);
    n_checks++; if (oDir !== 2'd3 || oHead_X !== 6'd21 || oHead_Y !== 5'd14) begin n_fail++; $display("FAIL rev_last_wins got dir=%0d (%0d,%0d) exp dir=3 (21,14)", oDir, oHead_X, oHead_Y); end
  endtask

  task automatic test_handshake_block();
    apply_reset();
    frames(7);
    iVGA_V_SYNC = 1'b0;
    clk1();
    iVGA_V_SYNC = 1'b1;
    iDir_Valid = 1'b1; iDir = 2'd1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (oDir_Ready !== 1'b0) begin n_fail++; $display("FAIL hs_busy%0d got=%0b exp=0", i, oDir_Ready); end
      clk1();
    end
    n_checks++; if (oDir_Ready !== 1'b1 || oStep !== 1'b1 || oDir !== 2'd0) begin n_fail++; $display("FAIL hs_idle got ready=%0b step=%0b dir=%0d exp 1 1 0", oDir_Ready, oStep, oDir); end
    clk1();
    iDir_Valid = 1'b0;
    n_checks++; if (oDir !== 2'd0) begin n_fail++; $display("FAIL hs_not_yet got=%0d exp=0", oDir); end
    frames(F);
    n_checks++; if (oDir !== 2'd1 || oHead_X !== 6'd21 || oHead_Y !== 5'd16) begin n_fail++; $display("FAIL hs_applied got dir=%0d (%0d,%0d) exp dir=1 (21,16)", oDir, oHead_X, oHead_Y); end
  endtask

  task automatic test_pause();
    int s;
    apply_reset();
    frames(3);
    iPause = 1'b1;
    s = step_seen;
    frames(20);
    n_checks++; if (oFrame_Cnt !== 8'd3 || step_seen != s) begin n_fail++; $display("FAIL pause_frozen got cnt=%0d steps=%0d exp cnt=3 steps=0", oFrame_Cnt, step_seen - s); end
    iPause = 1'b0;
    frames(4);
    n_checks++; if (oFrame_Cnt !== 8'd7 || step_seen != s) begin n_fail++; $display("FAIL pause_resume got cnt=%0d steps=%0d exp cnt=7 steps=0", oFrame_Cnt, step_seen - s); end
    frames(1);
    n_checks++; if (oFrame_Cnt !== 8'd0 || step_seen != s + 1 || oHead_X !== 6'd21) begin n_fail++; $display("FAIL pause_step got cnt=%0d steps=%0d x=%0d exp cnt=0 steps=1 x=21", oFrame_Cnt, step_seen - s, oHead_X); end
  endtask

  task automatic test_reset_mid_move();
    int s;
    apply_reset();
    iDir_Valid = 1'b1; iDir = 2'd1;
    clk1();
    iDir_Valid = 1'b0;
    frames(7);
    iVGA_V_SYNC = 1'b0;
    clk1();
    iVGA_V_SYNC = 1'b1;
    clk1();
    n_checks++; if (oDir_Ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_move got ready=%0b exp=0", oDir_Ready); end
    iRST_N = 1'b0;
    #1;
    n_checks++; if (oHead_X !== 6'd20 || oHead_Y !== 5'd15 || oDir !== 2'd0) begin n_fail++; $display("FAIL mid_reset_head got (%0d,%0d) dir=%0d exp (20,15) dir=0", oHead_X, oHead_Y, oDir); end
    n_checks++; if (oStep !== 1'b0 || oDir_Ready !== 1'b1 || oFrame_Cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset_ctl got step=%0b ready=%0b cnt=%0d exp 0 1 0", oStep, oDir_Ready, oFrame_Cnt); end
    clk1(); clk1();
    iRST_N = 1'b1;
    s = step_seen;
    repeat (8) clk1();
    n_checks++; if (step_seen != s || oHead_X !== 6'd20) begin n_fail++; $display("FAIL mid_no_step got steps=%0d x=%0d exp steps=0 x=20", step_seen - s, oHead_X); end
    frames(F);
    n_checks++; if (oDir !== 2'd0 || oHead_X !== 6'd21 || oHead_Y !== 5'd15) begin n_fail++; $display("FAIL mid_pend_dropped got dir=%0d (%0d,%0d) exp dir=0 (21,15)", oDir, oHead_X, oHead_Y); end
  endtask

  task automatic test_random();
    int errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!iVGA_V_SYNC) iVGA_V_SYNC = 1'b1;
      else iVGA_V_SYNC = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 39) == 0) iPause = ~iPause;
      if (!(iDir_Valid && m_busy != 0)) begin
        iDir_Valid = ($urandom_range(0, 2) == 0);
        iDir = 2'($urandom_range(0, 3));
      end
      clk1();
      n_checks++;
      if (oHead_X !== m_x || oHead_Y !== m_y || oDir !== m_dir || oStep !== m_step ||
          oDir_Ready !== (m_busy == 0) || oFrame_Cnt !== m_cnt) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand_cyc%0d got x=%0d y=%0d dir=%0d step=%0b rdy=%0b cnt=%0d exp x=%0d y=%0d dir=%0d step=%0b rdy=%0b cnt=%0d",
                   i, oHead_X, oHead_Y, oDir, oStep, oDir_Ready, oFrame_Cnt,
                   m_x, m_y, m_dir, m_step, (m_busy == 0), m_cnt);
        errs++;
      end
    end
    iPause = 1'b0; iDir_Valid = 1'b0; iVGA_V_SYNC = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_step();
    test_wrap();
    test_reverse();
    test_handshake_block();
    test_pause();
    test_reset_mid_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
